// File: rtl/dram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter_pkg
// Description : Shared CPU package. Holds the PC/ALU select enums used by the
//               core, plus the DRAM arbiter state encoding and requester
//               index constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_JUMP   = 2'd2,
    PC_SEL_TRAP   = 2'd3
  } pc_sel_t;

  typedef enum logic [2:0] {
    ALU_SEL_ADD = 3'd0,
    ALU_SEL_SUB = 3'd1,
    ALU_SEL_AND = 3'd2,
    ALU_SEL_OR  = 3'd3,
    ALU_SEL_XOR = 3'd4,
    ALU_SEL_SLT = 3'd5,
    ALU_SEL_SLL = 3'd6,
    ALU_SEL_SRL = 3'd7
  } alu_sel_t;

  // Arbiter ownership states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  localparam int REQ_CPU    = 0;  // bit 0: CPU data port
  localparam int REQ_DMA    = 1;  // bit 1: DMA / loader
  localparam int BEAT_CNT_W = 8;  // holds MAX_BURST up to 255

endpackage
`default_nettype wire

// File: rtl/dram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter_if
// Description : Requester-side bus of the DRAM arbiter (both requesters).
// Ports       : m_req_i/m_we_i/m_last_i  [1:0] per-requester request, write,
//               last beat; m0/m1 addr, write data, byte enables;
//               m_gnt_o, m_rd_valid_o [1:0]; rd_data_o shared read data.
//               modport master = requesters, modport slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]      m_req_i;
  logic [1:0]      m_we_i;
  logic [1:0]      m_last_i;
  logic [XLEN-1:0] m0_addr_i;
  logic [XLEN-1:0] m1_addr_i;
  logic [XLEN-1:0] m0_wr_data_i;
  logic [XLEN-1:0] m1_wr_data_i;
  logic [3:0]      m0_byte_en_i;
  logic [3:0]      m1_byte_en_i;
  logic [1:0]      m_gnt_o;
  logic [1:0]      m_rd_valid_o;
  logic [XLEN-1:0] rd_data_o;

  modport master (
    output m_req_i, m_we_i, m_last_i, m0_addr_i, m1_addr_i,
           m0_wr_data_i, m1_wr_data_i, m0_byte_en_i, m1_byte_en_i,
    input  m_gnt_o, m_rd_valid_o, rd_data_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_last_i, m0_addr_i, m1_addr_i,
           m0_wr_data_i, m1_wr_data_i, m0_byte_en_i, m1_byte_en_i,
    output m_gnt_o, m_rd_valid_o, rd_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Two-requester round-robin DRAM port arbiter with burst
//               ownership, MAX_BURST fairness cap and tagged read return.
// Ports       : clk_i, rst_n_i (async active-low); bus (dram_arbiter_if
//               slave: requests, grants, read valid/data); dram_rd_addr_o,
//               dram_wr_addr_o, dram_wr_data_o, dram_wr_byte_en_o to DRAM;
//               dram_rd_data_i from DRAM (1-cycle synchronous latency).
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  dram_arbiter_if.slave     bus,
  output logic [XLEN-1:0]   dram_rd_addr_o,
  output logic [XLEN-1:0]   dram_wr_addr_o,
  output logic [XLEN-1:0]   dram_wr_data_o,
  output logic [3:0]        dram_wr_byte_en_o,
  input  logic [XLEN-1:0]   dram_rd_data_i
);

  localparam logic [BEAT_CNT_W-1:0] BURST_MAX = BEAT_CNT_W'(MAX_BURST);

  arb_state_t            state, state_nxt;
  logic                  rr, rr_nxt;          // index of requester served last
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [1:0]            rd_tag, rd_tag_nxt;  // which requester a read returns to

  logic [1:0]            gnt;
  logic [1:0]            accept;
  logic                  owner;
  logic                  other;
  logic                  release_own;
  logic [BEAT_CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0]       sel_addr;
  logic [XLEN-1:0]       sel_wdata;
  logic [3:0]            sel_be;

  // Grant is a pure decode of the state register.
  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN_M0:  gnt = 2'b01;
      OWN_M1:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign owner  = (state == OWN_M1);
  assign other  = ~owner;
  assign accept = bus.m_req_i & gnt;

  // Beat count including the beat accepted this cycle, saturating. Using the
  // post-accept count lets the grant drop right after the MAX_BURST-th beat.
  assign cnt_inc = (|accept && beat_cnt != BURST_MAX) ? beat_cnt + 1'b1 : beat_cnt;

  always_comb begin
    state_nxt    = state;
    rr_nxt       = rr;
    beat_cnt_nxt = cnt_inc;
    release_own  = 1'b0;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (bus.m_req_i == 2'b11)
          state_nxt = rr ? OWN_M0 : OWN_M1;
        else if (bus.m_req_i[REQ_CPU])
          state_nxt = OWN_M0;
        else if (bus.m_req_i[REQ_DMA])
          state_nxt = OWN_M1;
      end
      OWN_M0, OWN_M1: begin
        release_own = (|accept && bus.m_last_i[owner])
                    || !bus.m_req_i[owner]
                    || (cnt_inc == BURST_MAX && bus.m_req_i[other]);
        if (release_own) begin
          rr_nxt       = owner;
          beat_cnt_nxt = '0;
          // Hand over directly when the other side is waiting.
          if (bus.m_req_i[other])
            state_nxt = owner ? OWN_M0 : OWN_M1;
          else
            state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  assign rd_tag_nxt = accept & ~bus.m_we_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      rr       <= 1'b1;  // "m1 served last" so m0 wins the first tie
      beat_cnt <= '0;
      rd_tag   <= 2'b00;
    end else begin
      state    <= state_nxt;
      rr       <= rr_nxt;
      beat_cnt <= beat_cnt_nxt;
      rd_tag   <= rd_tag_nxt;
    end
  end

  // DRAM side follows the owner; forced to zero while idle.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = 4'b0000;
    if (state == OWN_M0) begin
      sel_addr  = bus.m0_addr_i;
      sel_wdata = bus.m0_wr_data_i;
      sel_be    = bus.m0_byte_en_i;
    end else if (state == OWN_M1) begin
      sel_addr  = bus.m1_addr_i;
      sel_wdata = bus.m1_wr_data_i;
      sel_be    = bus.m1_byte_en_i;
    end
  end

  assign dram_rd_addr_o    = sel_addr;
  assign dram_wr_addr_o    = sel_addr;
  assign dram_wr_data_o    = sel_wdata;
  assign dram_wr_byte_en_o = (|(accept & bus.m_we_i)) ? sel_be : 4'b0000;

  assign bus.m_gnt_o      = gnt;
  assign bus.m_rd_valid_o = rd_tag;
  assign bus.rd_data_o    = (|rd_tag) ? dram_rd_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench for dram_arbiter (MAX_BURST = 4) with a
//               simple 1-cycle-latency DRAM model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dram_rd_addr, dram_wr_addr, dram_wr_data, dram_rd_data;
  logic [3:0]  dram_be;
  int          n_assert = 0;
  int          n_fail   = 0;

  dram_arbiter_if #(.XLEN(32)) bus ();

  dram_arbiter #(.XLEN(32), .MAX_BURST(4)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .bus               (bus),
    .dram_rd_addr_o    (dram_rd_addr),
    .dram_wr_addr_o    (dram_wr_addr),
    .dram_wr_data_o    (dram_wr_data),
    .dram_wr_byte_en_o (dram_be),
    .dram_rd_data_i    (dram_rd_data)
  );

  always #5 clk = ~clk;

  // DRAM read word is a tag OR'd with the address, one cycle later.
  initial dram_rd_data = 32'h0;
  always @(posedge clk) dram_rd_data <= 32'hD000_0000 | dram_rd_addr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  req, we, last;
    logic [31:0] a0, a1;
    logic [1:0]  gnt, rdv;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] last,
                       input logic [31:0] a0, input logic [31:0] a1);
    bus.m_req_i   = req;
    bus.m_we_i    = we;
    bus.m_last_i  = last;
    bus.m0_addr_i = a0;
    bus.m1_addr_i = a1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   {30'h0, bus.m_gnt_o}, 32'h0);
    check({tag, "_rdv"},   {30'h0, bus.m_rd_valid_o}, 32'h0);
    check({tag, "_be"},    {28'h0, dram_be}, 32'h0);
    check({tag, "_rdata"}, bus.rd_data_o, 32'h0);
    check({tag, "_raddr"}, dram_rd_addr, 32'h0);
    check({tag, "_waddr"}, dram_wr_addr, 32'h0);
  endtask

  logic [1:0] hist[1:9];
  int         idle_cnt;

  initial begin
    bus.m0_wr_data_i = 32'h1111_1111;
    bus.m1_wr_data_i = 32'hDEAD_BEEF;
    bus.m0_byte_en_i = 4'hC;
    bus.m1_byte_en_i = 4'h3;
    drive(2'b11, 2'b00, 2'b00, 32'h100, 32'h200);

    //          req    we     last   a0      a1      gnt    rdv    rdata          be    addr
    vecs[0]  = '{2'b01, 2'b00, 2'b01, 32'h100, 32'h000, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};
    vecs[1]  = '{2'b01, 2'b00, 2'b01, 32'h100, 32'h000, 2'b01, 2'b00, 32'h0,         4'h0, 32'h100};
    vecs[2]  = '{2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 2'b00, 2'b01, 32'hD0000100,  4'h0, 32'h000};
    vecs[3]  = '{2'b11, 2'b11, 2'b00, 32'h200, 32'h020, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};
    vecs[4]  = '{2'b11, 2'b11, 2'b00, 32'h200, 32'h020, 2'b10, 2'b00, 32'h0,         4'h3, 32'h020};
    vecs[5]  = '{2'b11, 2'b11, 2'b10, 32'h200, 32'h024, 2'b10, 2'b00, 32'h0,         4'h3, 32'h024};
    vecs[6]  = '{2'b01, 2'b01, 2'b01, 32'h204, 32'h000, 2'b01, 2'b00, 32'h0,         4'hC, 32'h204};
    vecs[7]  = '{2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};
    vecs[8]  = '{2'b01, 2'b00, 2'b00, 32'h300, 32'h400, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};
    vecs[9]  = '{2'b11, 2'b00, 2'b01, 32'h300, 32'h400, 2'b01, 2'b00, 32'h0,         4'h0, 32'h300};
    vecs[10] = '{2'b10, 2'b00, 2'b10, 32'h000, 32'h400, 2'b10, 2'b01, 32'hD0000300,  4'h0, 32'h400};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 2'b00, 2'b10, 32'hD0000400,  4'h0, 32'h000};
    vecs[12] = '{2'b10, 2'b00, 2'b00, 32'h000, 32'h500, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 32'h000, 32'h500, 2'b10, 2'b00, 32'h0,         4'h0, 32'h500};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 2'b00, 2'b00, 32'h0,         4'h0, 32'h000};

    // Reset state, with requests already asserted.
    @(negedge clk);
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Table: inputs applied at negedge, outputs checked in the same cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].last, vecs[i].a0, vecs[i].a1);
      #2;
      check($sformatf("v%0d_gnt", i),   {30'h0, bus.m_gnt_o},      {30'h0, vecs[i].gnt});
      check($sformatf("v%0d_rdv", i),   {30'h0, bus.m_rd_valid_o}, {30'h0, vecs[i].rdv});
      check($sformatf("v%0d_rdata", i), bus.rd_data_o,             vecs[i].rdata);
      check($sformatf("v%0d_be", i),    {28'h0, dram_be},          {28'h0, vecs[i].be});
      check($sformatf("v%0d_raddr", i), dram_rd_addr,              vecs[i].addr);
      check($sformatf("v%0d_waddr", i), dram_wr_addr,              vecs[i].addr);
      @(negedge clk);
    end

    // Burst cap: both stream without last, from reset -> m0 first, 4 beats each.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 32'h40, 32'h80);
    idle_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      #2;
      hist[c] = bus.m_gnt_o;
      if (bus.m_gnt_o == 2'b00) idle_cnt++;
    end
    check("burst_first_m0", {30'h0, hist[1]}, 32'h1);
    check("burst_m0_beat4", {30'h0, hist[4]}, 32'h1);
    check("burst_m1_take",  {30'h0, hist[5]}, 32'h2);
    check("burst_m1_beat4", {30'h0, hist[8]}, 32'h2);
    check("burst_m0_back",  {30'h0, hist[9]}, 32'h1);
    check("burst_no_idle",  idle_cnt, 32'h0);

    // Saturation: m0 alone keeps the port past MAX_BURST, yields once m1 asks.
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 32'h60, 32'h90);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("sat_m0_c%0d", c), {30'h0, bus.m_gnt_o}, 32'h1);
    end
    bus.m_req_i = 2'b11;
    @(negedge clk);
    #2;
    check("sat_handover", {30'h0, bus.m_gnt_o}, 32'h2);

    // Write strobes from m1 only in the accept cycle.
    do_reset();
    drive(2'b10, 2'b10, 2'b10, 32'h0, 32'h20);
    #2;
    check("wr_pre_be", {28'h0, dram_be}, 32'h0);
    @(negedge clk);
    #2;
    check("wr_gnt",   {30'h0, bus.m_gnt_o}, 32'h2);
    check("wr_be",    {28'h0, dram_be}, 32'h3);
    check("wr_data",  dram_wr_data, 32'hDEAD_BEEF);
    check("wr_addr",  dram_wr_addr, 32'h20);
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    check("wr_post_be", {28'h0, dram_be}, 32'h0);

    // Reset mid-burst: outputs clear at once, no late read valid.
    drive(2'b01, 2'b00, 2'b00, 32'h700, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("mid_gnt_before", {30'h0, bus.m_gnt_o}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    #2;
    check("midrst_no_rdv", {30'h0, bus.m_rd_valid_o}, 32'h0);
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    check("midrst_m0_first", {30'h0, bus.m_gnt_o}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
